// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and
// the fixed instruction-memory response latency.
package fetch_pkg;

  localparam int unsigned MEM_LAT = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular buffer holding fetched instructions with their PCs.
// Synchronous flush; a push into a full buffer is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned Width = 96,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues sequential fetches to a fixed-latency memory,
// buffers responses for the core and handles redirects by dropping stale responses.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 64,
  parameter int unsigned        INST_W     = 32,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [ADDR_W-1:0]  PC_LIMIT   = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_imem_valid,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_inst,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_done
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntW = INST_W + ADDR_W;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic [CntW-1:0]   drop_q, drop_d;

  logic              issue, resp_v, push, pop, flush;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty;
  logic [EntW-1:0]   fifo_rdata;
  logic [CntW:0]     credit_used;

  // Responses with nothing outstanding are leftovers from before reset.
  assign resp_v = i_imem_valid && (inflight_q != '0);

  // Every outstanding request, dropped or not, holds a buffer slot until it returns.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue = (state_q == StRun) && !i_redirect && (pc_q < PC_LIMIT) && (credit_used < DepthC);

  assign push  = resp_v && !i_redirect && (drop_q == '0);
  assign pop   = o_inst_valid && i_inst_ready && !i_redirect;
  assign flush = i_redirect && (state_q != StIdle);

  always_comb begin
    unique case ({issue, resp_v})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StRun;
      end
      StRun: begin
        if (!i_redirect && (pc_q == PC_LIMIT) && (inflight_q == '0) && fifo_empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (i_redirect) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    if (i_redirect) begin
      pc_d      = i_redirect_pc;
      resp_pc_d = i_redirect_pc;
      if (state_q != StIdle) drop_d = resp_v ? inflight_q - CntW'(1) : inflight_q;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(4);
      if (resp_v) begin
        if (drop_q != '0) drop_d = drop_q - CntW'(1);
        else resp_pc_d = resp_pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .Width (EntW),
    .Depth (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .flush_i (flush),
    .push_i  (push),
    .data_i  ({resp_pc_q, i_imem_inst}),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign o_imem_valid = issue;
  assign o_imem_addr  = pc_q;
  assign o_inst_valid = !fifo_empty;
  assign o_inst       = fifo_empty ? '0 : fifo_rdata[INST_W-1:0];
  assign o_inst_pc    = fifo_empty ? RESET_PC : fifo_rdata[EntW-1:INST_W];
  assign o_done       = (state_q == StDone);

endmodule
